// File: rtl/railway_crossing_ctrl.sv
// railway_crossing_ctrl
// Level-crossing controller for N_TRACKS independent tracks. Any detector high
// starts a timed warn -> lower -> closed -> clear -> raise sequence that drives the
// gate actuator and the signal lights. Re-detection during raise reverses the
// gate. A watchdog on the closed period latches a sticky fault. All outputs are
// registered (Moore).
//
// Ports
//   i_clk            rising-edge clock
//   i_reset          asynchronous, active-high reset
//   i_rail_detect    per-track train present
//   o_gate           00 open, 01 lowering, 10 closed, 11 raising
//   o_light          001 green, 010 yellow, 100 red, 111 fault
//   o_state          FSM state encoding
//   o_occupied       registered popcount of i_rail_detect (informational)
//   o_closure_count  completed closures, wraps at 2^CNT_W
//   o_fault          sticky watchdog fault
module railway_crossing_ctrl #(
  parameter int unsigned N_TRACKS     = 2,
  parameter int unsigned WARN_CYCLES  = 4,
  parameter int unsigned GATE_CYCLES  = 3,
  parameter int unsigned CLEAR_CYCLES = 2,
  parameter int unsigned MAX_CLOSED   = 64,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                              i_clk,
  input  logic                              i_reset,
  input  logic [N_TRACKS-1:0]               i_rail_detect,
  output logic [1:0]                        o_gate,
  output logic [2:0]                        o_light,
  output logic [2:0]                        o_state,
  output logic [$clog2(N_TRACKS+1)-1:0]     o_occupied,
  output logic [CNT_W-1:0]                  o_closure_count,
  output logic                              o_fault
);

  localparam int unsigned OCC_W = $clog2(N_TRACKS + 1);
  // Watchdog gets its own width so MAX_CLOSED is representable whatever CNT_W is.
  localparam int unsigned WD_W  = $clog2(MAX_CLOSED + 1);

  // Timers are loaded with (cycles - 1) so a state lasts exactly its parameter.
  localparam logic [CNT_W-1:0] WARN_LD  = CNT_W'(WARN_CYCLES - 1);
  localparam logic [CNT_W-1:0] GATE_LD  = CNT_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LD = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(MAX_CLOSED);

  typedef enum logic [2:0] {
    StIdle   = 3'b000,
    StWarn   = 3'b001,
    StLower  = 3'b010,
    StClosed = 3'b011,
    StClear  = 3'b100,
    StRaise  = 3'b101
  } state_e;

  state_e             r_state;
  logic [CNT_W-1:0]   r_timer;
  logic [WD_W-1:0]    r_wd;
  logic               r_fault;
  logic [CNT_W-1:0]   r_count;
  logic [1:0]         r_gate;
  logic [2:0]         r_light;
  logic [OCC_W-1:0]   r_occ;

  state_e             w_state_nxt;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic [WD_W-1:0]    w_wd_nxt;
  logic [WD_W-1:0]    w_wd_inc;
  logic               w_fault_nxt;
  logic [CNT_W-1:0]   w_count_nxt;
  logic [OCC_W-1:0]   w_popcnt;
  logic               w_det;
  logic               w_in_closed;
  logic               w_timer_done;

  function automatic logic [1:0] gate_of(input state_e st);
    case (st)
      StIdle, StWarn:   gate_of = 2'b00;
      StLower:          gate_of = 2'b01;
      StClosed, StClear: gate_of = 2'b10;
      StRaise:          gate_of = 2'b11;
      default:          gate_of = 2'b01;
    endcase
  endfunction

  function automatic logic [2:0] light_of(input state_e st, input logic flt);
    if (flt) begin
      light_of = 3'b111;
    end else begin
      case (st)
        StIdle:          light_of = 3'b001;
        StWarn, StRaise: light_of = 3'b010;
        default:         light_of = 3'b100;
      endcase
    end
  endfunction

  always_comb begin
    w_popcnt = '0;
    for (int i = 0; i < int'(N_TRACKS); i++) begin
      w_popcnt = w_popcnt + OCC_W'(i_rail_detect[i]);
    end
  end

  assign w_det        = |i_rail_detect;
  assign w_in_closed  = (r_state == StClosed) || (r_state == StClear);
  assign w_wd_inc     = r_wd + WD_W'(1);
  assign w_timer_done = (r_timer == '0);

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_wd_nxt    = r_wd;
    w_fault_nxt = r_fault;
    w_count_nxt = r_count;
    if (r_fault) begin
      // Latched fault: hold the gate down and ignore detectors until reset.
      w_state_nxt = StClosed;
    end else if (w_in_closed && (w_wd_inc == WD_MAX)) begin
      // Expiry beats any simultaneous detector change.
      w_fault_nxt = 1'b1;
      w_state_nxt = StClosed;
      w_wd_nxt    = w_wd_inc;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_det) begin
            w_state_nxt = StWarn;
            w_timer_nxt = WARN_LD;
          end
        end
        StWarn: begin
          // Warning always runs to completion, even if the train vanishes.
          if (w_timer_done) begin
            w_state_nxt = StLower;
            w_timer_nxt = GATE_LD;
            w_wd_nxt    = '0;
          end else begin
            w_timer_nxt = r_timer - CNT_W'(1);
          end
        end
        StLower: begin
          if (w_timer_done) begin
            w_state_nxt = StClosed;
          end else begin
            w_timer_nxt = r_timer - CNT_W'(1);
          end
        end
        StClosed: begin
          w_wd_nxt = w_wd_inc;
          if (!w_det) begin
            w_state_nxt = StClear;
            w_timer_nxt = CLEAR_LD;
          end
        end
        StClear: begin
          if (w_det) begin
            w_state_nxt = StClosed;
            w_timer_nxt = '0;
            w_wd_nxt    = w_wd_inc;
          end else if (w_timer_done) begin
            w_state_nxt = StRaise;
            w_timer_nxt = GATE_LD;
            w_wd_nxt    = '0;
          end else begin
            w_timer_nxt = r_timer - CNT_W'(1);
            w_wd_nxt    = w_wd_inc;
          end
        end
        StRaise: begin
          if (w_det) begin
            // Reversal: full lowering time from wherever the gate is.
            w_state_nxt = StLower;
            w_timer_nxt = GATE_LD;
            w_wd_nxt    = '0;
          end else if (w_timer_done) begin
            w_state_nxt = StIdle;
            w_count_nxt = r_count + CNT_W'(1);
          end else begin
            w_timer_nxt = r_timer - CNT_W'(1);
          end
        end
        default: begin
          // Unreachable encodings fail safe toward a lowered gate.
          w_state_nxt = StLower;
          w_timer_nxt = GATE_LD;
          w_wd_nxt    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state <= StIdle;
      r_timer <= '0;
      r_wd    <= '0;
      r_fault <= 1'b0;
      r_count <= '0;
      r_gate  <= 2'b00;
      r_light <= 3'b001;
      r_occ   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_wd    <= w_wd_nxt;
      r_fault <= w_fault_nxt;
      r_count <= w_count_nxt;
      r_gate  <= gate_of(w_state_nxt);
      r_light <= light_of(w_state_nxt, w_fault_nxt);
      r_occ   <= w_popcnt;
    end
  end

  assign o_gate          = r_gate;
  assign o_light         = r_light;
  assign o_state         = r_state;
  assign o_occupied      = r_occ;
  assign o_closure_count = r_count;
  assign o_fault         = r_fault;

endmodule

// File: tb/tb_railway_crossing_ctrl.sv
// Directed bench for railway_crossing_ctrl. Three instances: defaults (u_dut0),
// MAX_CLOSED=8 (u_dut1) and CNT_W=2 (u_dut2). Outputs are sampled on the falling
// clock edge; inputs change there too.
module tb_railway_crossing_ctrl;

  logic       clk;
  logic       rst0, rst1, rst2;
  logic [1:0] det0, det1, det2;
  logic [1:0] gate0, gate1, gate2;
  logic [2:0] light0, light1, light2;
  logic [2:0] state0, state1, state2;
  logic [1:0] occ0, occ1, occ2;
  logic [7:0] cnt0, cnt1;
  logic [1:0] cnt2;
  logic       fault0, fault1, fault2;

  int checks   = 0;
  int failures = 0;

  railway_crossing_ctrl u_dut0 (
    .i_clk(clk), .i_reset(rst0), .i_rail_detect(det0), .o_gate(gate0), .o_light(light0),
    .o_state(state0), .o_occupied(occ0), .o_closure_count(cnt0), .o_fault(fault0)
  );

  railway_crossing_ctrl #(.MAX_CLOSED(8)) u_dut1 (
    .i_clk(clk), .i_reset(rst1), .i_rail_detect(det1), .o_gate(gate1), .o_light(light1),
    .o_state(state1), .o_occupied(occ1), .o_closure_count(cnt1), .o_fault(fault1)
  );

  railway_crossing_ctrl #(.CNT_W(2)) u_dut2 (
    .i_clk(clk), .i_reset(rst2), .i_rail_detect(det2), .o_gate(gate2), .o_light(light2),
    .o_state(state2), .o_occupied(occ2), .o_closure_count(cnt2), .o_fault(fault2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    #2;
    checks++; if ({state0, gate0, light0, occ0, cnt0, fault0} !== {3'd0, 2'd0, 3'b001, 2'd0, 8'd0, 1'b0}) begin
      failures++; $display("FAIL reset_dut0 got=%h want=%h", {state0, gate0, light0, occ0, cnt0, fault0}, {3'd0, 2'd0, 3'b001, 2'd0, 8'd0, 1'b0});
    end
    checks++; if ({state1, gate1, light1, occ1, cnt1, fault1} !== {3'd0, 2'd0, 3'b001, 2'd0, 8'd0, 1'b0}) begin
      failures++; $display("FAIL reset_dut1 got=%h want=%h", {state1, gate1, light1, occ1, cnt1, fault1}, {3'd0, 2'd0, 3'b001, 2'd0, 8'd0, 1'b0});
    end
    checks++; if ({state2, gate2, light2, occ2, cnt2, fault2} !== {3'd0, 2'd0, 3'b001, 2'd0, 2'd0, 1'b0}) begin
      failures++; $display("FAIL reset_dut2 got=%h want=%h", {state2, gate2, light2, occ2, cnt2, fault2}, {3'd0, 2'd0, 3'b001, 2'd0, 2'd0, 1'b0});
    end
    @(negedge clk); @(negedge clk);
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clk);
    checks++; if (state0 !== 3'd0 || gate0 !== 2'd0) begin
      failures++; $display("FAIL idle_after_reset state=%0d gate=%0d want 0 0", state0, gate0);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_st [18];
    logic [1:0] exp_gt [18];
    logic [2:0] exp_lt [18];
    logic [1:0] exp_oc;
    exp_st = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
               3'd4, 3'd4, 3'd5, 3'd5, 3'd5, 3'd0};
    exp_gt = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
               2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    exp_lt = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4,
               3'd4, 3'd4, 3'd2, 3'd2, 3'd2, 3'd1};
    det0 = 2'b01;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      exp_oc = (i < 12) ? 2'd1 : 2'd0;
      checks++; if (state0 !== exp_st[i]) begin
        failures++; $display("FAIL basic_state cyc=%0d got=%0d want=%0d", i, state0, exp_st[i]);
      end
      checks++; if (gate0 !== exp_gt[i]) begin
        failures++; $display("FAIL basic_gate cyc=%0d got=%0d want=%0d", i, gate0, exp_gt[i]);
      end
      checks++; if (light0 !== exp_lt[i]) begin
        failures++; $display("FAIL basic_light cyc=%0d got=%b want=%b", i, light0, exp_lt[i]);
      end
      checks++; if (occ0 !== exp_oc) begin
        failures++; $display("FAIL basic_occ cyc=%0d got=%0d want=%0d", i, occ0, exp_oc);
      end
      if (i == 16) begin
        checks++; if (cnt0 !== 8'd0) begin
          failures++; $display("FAIL basic_count_early got=%0d want=0", cnt0);
        end
      end
      if (i == 11) det0 = 2'b00;
    end
    checks++; if (cnt0 !== 8'd1) begin
      failures++; $display("FAIL basic_count got=%0d want=1", cnt0);
    end
  endtask

  task automatic test_clear_abort();
    int n;
    det0 = 2'b10;
    repeat (8) @(negedge clk);
    checks++; if (state0 !== 3'd3 || gate0 !== 2'd2) begin
      failures++; $display("FAIL abort_closed state=%0d gate=%0d want 3 2", state0, gate0);
    end
    det0 = 2'b00;
    @(negedge clk);
    checks++; if (state0 !== 3'd4) begin
      failures++; $display("FAIL abort_clear1 got=%0d want=4", state0);
    end
    @(negedge clk);
    checks++; if (state0 !== 3'd4) begin
      failures++; $display("FAIL abort_clear2 got=%0d want=4", state0);
    end
    det0 = 2'b10;
    @(negedge clk);
    checks++; if (state0 !== 3'd3 || gate0 !== 2'd2 || cnt0 !== 8'd1 || occ0 !== 2'd1) begin
      failures++; $display("FAIL abort_back st=%0d gate=%0d cnt=%0d occ=%0d want 3 2 1 1", state0, gate0, cnt0, occ0);
    end
    repeat (3) @(negedge clk);
    checks++; if (state0 !== 3'd3) begin
      failures++; $display("FAIL abort_hold got=%0d want=3", state0);
    end
    det0 = 2'b00;
    n = 0;
    while (state0 !== 3'd0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (state0 !== 3'd0) begin
      failures++; $display("FAIL abort_timeout state=%0d want=0", state0);
    end
    checks++; if (cnt0 !== 8'd2) begin
      failures++; $display("FAIL abort_count got=%0d want=2", cnt0);
    end
  endtask

  task automatic test_raise_reversal();
    int n;
    det0 = 2'b01;
    repeat (8) @(negedge clk);
    checks++; if (state0 !== 3'd3) begin
      failures++; $display("FAIL rev_closed got=%0d want=3", state0);
    end
    det0 = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (state0 !== 3'd5 || gate0 !== 2'd3) begin
      failures++; $display("FAIL rev_raise1 state=%0d gate=%0d want 5 3", state0, gate0);
    end
    @(negedge clk);
    checks++; if (state0 !== 3'd5) begin
      failures++; $display("FAIL rev_raise2 got=%0d want=5", state0);
    end
    det0 = 2'b01;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (state0 !== 3'd2 || gate0 !== 2'd1 || light0 !== 3'b100) begin
        failures++; $display("FAIL rev_lower cyc=%0d st=%0d gate=%0d light=%b want 2 1 100", i, state0, gate0, light0);
      end
    end
    @(negedge clk);
    checks++; if (state0 !== 3'd3 || gate0 !== 2'd2 || cnt0 !== 8'd2) begin
      failures++; $display("FAIL rev_closed2 st=%0d gate=%0d cnt=%0d want 3 2 2", state0, gate0, cnt0);
    end
    det0 = 2'b00;
    n = 0;
    while (state0 !== 3'd0 && n < 20) begin @(negedge clk); n++; end
    checks++; if (state0 !== 3'd0 || cnt0 !== 8'd3) begin
      failures++; $display("FAIL rev_finish st=%0d cnt=%0d want 0 3", state0, cnt0);
    end
  endtask

  task automatic test_warn_completes();
    det0 = 2'b01;
    @(negedge clk);
    checks++; if (state0 !== 3'd1) begin
      failures++; $display("FAIL warn_enter got=%0d want=1", state0);
    end
    det0 = 2'b00;
    repeat (3) @(negedge clk);
    checks++; if (state0 !== 3'd1) begin
      failures++; $display("FAIL warn_last got=%0d want=1", state0);
    end
    @(negedge clk);
    checks++; if (state0 !== 3'd2 || gate0 !== 2'd1) begin
      failures++; $display("FAIL warn_lower st=%0d gate=%0d want 2 1", state0, gate0);
    end
    repeat (3) @(negedge clk);
    checks++; if (state0 !== 3'd3) begin
      failures++; $display("FAIL warn_closed got=%0d want=3", state0);
    end
    @(negedge clk);
    checks++; if (state0 !== 3'd4) begin
      failures++; $display("FAIL warn_clear got=%0d want=4", state0);
    end
    repeat (5) @(negedge clk);
    checks++; if (state0 !== 3'd0 || cnt0 !== 8'd4) begin
      failures++; $display("FAIL warn_finish st=%0d cnt=%0d want 0 4", state0, cnt0);
    end
  endtask

  task automatic test_async_reset();
    det0 = 2'b01;
    repeat (5) @(negedge clk);
    checks++; if (state0 !== 3'd2 || gate0 !== 2'd1) begin
      failures++; $display("FAIL areset_pre st=%0d gate=%0d want 2 1", state0, gate0);
    end
    @(posedge clk);
    #3;
    rst0 = 1'b1;
    #1;
    checks++; if (state0 !== 3'd0 || gate0 !== 2'd0 || light0 !== 3'b001 || cnt0 !== 8'd0) begin
      failures++; $display("FAIL areset_now st=%0d gate=%0d light=%b cnt=%0d want 0 0 001 0", state0, gate0, light0, cnt0);
    end
    @(negedge clk);
    rst0 = 1'b0;
    det0 = 2'b00;
    @(negedge clk);
    checks++; if (state0 !== 3'd0) begin
      failures++; $display("FAIL areset_idle got=%0d want=0", state0);
    end
  endtask

  task automatic test_watchdog();
    logic [2:0] exp_st;
    det1 = 2'b11;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      exp_st = (i < 4) ? 3'd1 : (i < 7) ? 3'd2 : 3'd3;
      checks++; if (state1 !== exp_st) begin
        failures++; $display("FAIL wd_state cyc=%0d got=%0d want=%0d", i, state1, exp_st);
      end
      checks++; if (fault1 !== (i == 15)) begin
        failures++; $display("FAIL wd_fault cyc=%0d got=%0d want=%0d", i, fault1, (i == 15));
      end
      if (i < 15) begin
        checks++; if (occ1 !== 2'd2) begin
          failures++; $display("FAIL wd_occ cyc=%0d got=%0d want=2", i, occ1);
        end
      end
      // Detector falls on the same edge the watchdog expires.
      if (i == 14) det1 = 2'b00;
    end
    checks++; if (light1 !== 3'b111 || gate1 !== 2'd2) begin
      failures++; $display("FAIL wd_outputs light=%b gate=%0d want 111 2", light1, gate1);
    end
    repeat (3) @(negedge clk);
    det1 = 2'b01;
    repeat (3) @(negedge clk);
    checks++; if (state1 !== 3'd3 || fault1 !== 1'b1 || light1 !== 3'b111 || gate1 !== 2'd2) begin
      failures++; $display("FAIL wd_hold st=%0d fault=%0d light=%b gate=%0d want 3 1 111 2", state1, fault1, light1, gate1);
    end
    rst1 = 1'b1;
    #1;
    checks++; if (state1 !== 3'd0 || fault1 !== 1'b0 || light1 !== 3'b001) begin
      failures++; $display("FAIL wd_reset st=%0d fault=%0d light=%b want 0 0 001", state1, fault1, light1);
    end
    @(negedge clk);
    det1 = 2'b00;
    rst1 = 1'b0;
  endtask

  task automatic test_counter_wrap();
    logic [1:0] exp_cnt [5];
    int n;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    for (int k = 0; k < 5; k++) begin
      det2 = 2'b01;
      repeat (8) @(negedge clk);
      det2 = 2'b00;
      n = 0;
      while (state2 !== 3'd0 && n < 20) begin @(negedge clk); n++; end
      checks++; if (state2 !== 3'd0) begin
        failures++; $display("FAIL wrap_timeout k=%0d state=%0d want=0", k, state2);
      end
      checks++; if (cnt2 !== exp_cnt[k]) begin
        failures++; $display("FAIL wrap_count k=%0d got=%0d want=%0d", k, cnt2, exp_cnt[k]);
      end
    end
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    det0 = 2'b00; det1 = 2'b00; det2 = 2'b00;
    test_reset();
    test_basic();
    test_clear_abort();
    test_raise_reversal();
    test_warn_completes();
    test_async_reset();
    test_watchdog();
    test_counter_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/railway_crossing_ctrl.md
# railway_crossing_ctrl

Parametrised level-crossing controller for N independent tracks. Monitors per-track train detectors, runs a timed warn → lower → closed → clear → raise sequence, and drives the gate actuator and the signal lights. Adds a reversal on re-detection during raise, a closure watchdog with a sticky fault, and a wrapping closure counter. All outputs are registered (Moore).

## Interface
- N_TRACKS, 2, number of detector inputs (≥1)
- WARN_CYCLES, 4, cycles spent in WARN before lowering (≥1)
- GATE_CYCLES, 3, cycles for a full gate lower or raise (≥1)
- CLEAR_CYCLES, 2, cycles all detectors must stay low before raising (≥1)
- MAX_CLOSED, 64, watchdog limit on consecutive CLOSED+CLEAR cycles (≥2)
- CNT_W, 8, width of timers and of closure_count
- clk  input  1  single clock; all state changes on rising edge
- reset  input  1  asynchronous, active-high; forces reset values immediately
- rail_detect  input  N_TRACKS  bit i high = train present on track i
- gate  output  2  00 open, 01 lowering, 10 closed, 11 raising
- light  output  3  001 green, 010 yellow, 100 red, 111 fault
- state  output  3  current FSM state encoding
- occupied  output  $clog2(N_TRACKS+1)  registered popcount of rail_detect
- closure_count  output  CNT_W  completed closures, wraps at 2^CNT_W
- fault  output  1  sticky watchdog fault

## Operation
- States: IDLE 000, WARN 001, LOWER 010, CLOSED 011, CLEAR 100, RAISE 101. 110/111 unreachable; if reached, go to LOWER (fail safe).
- "det" = OR of rail_detect.
- IDLE: gate 00, light 001. det → WARN.
- WARN: gate 00, light 010. Always completes, even if det drops. After WARN_CYCLES → LOWER.
- LOWER: gate 01, light 100. After GATE_CYCLES → CLOSED.
- CLOSED: gate 10, light 100. Stay while det. When det is low → CLEAR.
- CLEAR: gate 10, light 100. det → CLOSED, clear timer discarded. After CLEAR_CYCLES with det low → RAISE.
- RAISE: gate 11, light 010. det → LOWER with the timer reloaded to GATE_CYCLES (reversal). After GATE_CYCLES → IDLE, and closure_count increments by 1 on that transition.
- Watchdog: a counter runs while the state is CLOSED or CLEAR. It clears on entry to LOWER and on leaving CLEAR toward RAISE. When it reaches MAX_CLOSED, fault is set.
- While fault is set:
  - FSM holds in CLOSED; gate 10, light 111.
  - Detectors are ignored; only reset clears fault.
- occupied = popcount of rail_detect sampled each cycle. It is informational only and does not affect the FSM.
- Reset values: state IDLE, gate 00, light 001, occupied 0, closure_count 0, fault 0, all timers 0.
- Reset asserted mid-sequence (e.g. gate closed): outputs return to the open values immediately and asynchronously. Safety after reset is the system's responsibility, not this block's.

## Timing
- Inputs are sampled on rising clk edges. A state change and its outputs are visible one cycle after the deciding sample.
- Timed states last exactly their parameter in cycles. Example: entered at edge k with WARN_CYCLES=4 → leaves at edge k+4.
- Detect-to-gate-moving latency: 1 + WARN_CYCLES cycles (IDLE→WARN edge, then the WARN dwell).
- Detect-to-gate-closed latency: 1 + WARN_CYCLES + GATE_CYCLES cycles.
- Minimum last-clear-to-open time: 1 + CLEAR_CYCLES + GATE_CYCLES cycles.
- Simultaneous events:
  - det rising on the final cycle of CLEAR or RAISE: the det transition wins (CLOSED / LOWER).
  - Watchdog expiry together with det falling: fault wins.
- closure_count wraps silently from 2^CNT_W−1 to 0.

## Test plan
- **Basic sequence.** Defaults; reset 20 ns; rail_detect=01 for 12 cycles, then 00.
  - Expect states 000→001 (4 cycles)→010 (3)→011→100 (2)→101 (3)→000.
  - Expect gate 00,00,01,10,10,11,00; closure_count=1.
- **Clear abort.** rail_detect=10 drops to 00, then returns to 10 on the 2nd CLEAR cycle → state back to 011, gate 10, closure_count unchanged.
- **Raise reversal.** Re-assert rail_detect=01 during the 2nd RAISE cycle → LOWER (gate 01) for 3 full cycles, then CLOSED.
- **Watchdog.** MAX_CLOSED=8; hold rail_detect=11.
  - After 8 cycles in CLOSED: fault=1, light=111, gate=10; occupied=2 throughout.
  - Dropping detect has no effect on the FSM; reset clears fault and returns state 000, light 001.
- **Async reset mid-close.** Assert reset between clock edges while in LOWER → gate=00, state=000 before the next edge.
- **Counter wrap.** CNT_W=2; run 5 complete closures → closure_count sequence 1,2,3,0,1.
